// File: rtl/counter_display_pkg.sv
// Shared types, constants and helpers for the counter_display pipeline.
package counter_display_pkg;

  // Counter modes as presented on i_mode.
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  // Serial binary-to-BCD converter states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } conv_state_e;

  // Active-low seven-segment codes, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Encode one BCD nibble; non-decimal codes blank the digit.
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // 10**n for small n, usable in elaboration-time checks.
  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_serial_converter.sv
// Sequential double-dabble converter with a single-entry pending request.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting; captures i_bin when a request or pending flag is set
//   ST_SHIFT | WIDTH cycles of add-3-then-shift over {bcd, bin}
//   ST_DONE  | one cycle; o_done tells the parent to latch o_bcd
module bcd_serial_converter
  import counter_display_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req,
  input  logic [WIDTH-1:0]      i_bin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd
);

  localparam int CW = $clog2(WIDTH + 1);

  conv_state_e           r_state;
  conv_state_e           w_state_nxt;
  logic                  r_pend;
  logic                  r_busy;
  logic [WIDTH-1:0]      r_bin;
  logic [4*DIGITS-1:0]   r_bcd;
  logic [CW-1:0]         r_cnt;
  logic                  w_capture;
  logic                  w_shift;
  logic [4*DIGITS-1:0]   w_bcd_adj;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state; the shift down-counter reaching zero marks the last shift.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req || r_pend) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_shift = 1'b1;
        if (r_cnt == '0) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Add-3 correction of every BCD nibble that is 5 or more.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5) w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
    end
  end

  // Datapath: capture, shift, pending flag and registered busy.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_pend <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != ST_IDLE);
      if (w_capture) begin
        r_bin  <= i_bin;
        r_bcd  <= '0;
        r_cnt  <= CW'(WIDTH - 1);
        r_pend <= 1'b0;
      end else begin
        // Only one pending slot: later requests overwrite nothing, the capture
        // simply takes whatever count is current at that moment.
        if (i_req) r_pend <= 1'b1;
        if (w_shift) begin
          {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
          r_cnt          <= r_cnt - CW'(1);
        end
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = (r_state == ST_DONE);
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/counter_display.sv
// Prescaler, mode-controlled counter and seven-segment output stage around
// the serial BCD converter.
module counter_display
  import counter_display_pkg::*;
#(
  parameter int DIV    = 25000000,
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [1:0]            i_mode,
  input  logic [WIDTH-1:0]      i_load,
  output logic                  o_tick,
  output logic [WIDTH-1:0]      o_count,
  output logic                  o_busy,
  output logic                  o_upd,
  output logic [7*DIGITS-1:0]   o_sseg
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("counter_display: WIDTH must be 2..16");
  end
  if (DIGITS > 5) begin : g_bad_digits
    $error("counter_display: DIGITS must not exceed 5");
  end else if (pow10(DIGITS) <= (2 ** WIDTH) - 1) begin : g_few_digits
    $error("counter_display: DIGITS too small for WIDTH");
  end

  logic [PW-1:0]         r_presc;
  logic [PW-1:0]         w_presc_nxt;
  logic                  r_tick;
  logic [WIDTH-1:0]      r_count;
  logic                  r_req;
  logic                  r_upd;
  logic [7*DIGITS-1:0]   r_sseg;
  logic                  w_busy;
  logic                  w_done;
  logic [4*DIGITS-1:0]   w_bcd;

  // The tick cycle always completes (wrap to 0) even if i_en drops in it.
  always_comb begin
    w_presc_nxt = r_presc;
    if (r_tick)    w_presc_nxt = '0;
    else if (i_en) w_presc_nxt = r_presc + PW'(1);
  end

  // Prescaler and registered tick aligned with the DIV-1 prescaler value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_presc <= w_presc_nxt;
      r_tick  <= (w_presc_nxt == PW'(DIV - 1));
    end
  end

  // Counter update on each tick; every write raises a conversion request.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
      r_req   <= 1'b0;
    end else begin
      r_req <= r_tick;
      if (r_tick) begin
        case (mode_e'(i_mode))
          MODE_UP:   r_count <= r_count + WIDTH'(1);
          MODE_DOWN: r_count <= r_count - WIDTH'(1);
          MODE_LOAD: r_count <= i_load;
          default:   r_count <= r_count;
        endcase
      end
    end
  end

  bcd_serial_converter #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_conv (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_req  (r_req),
    .i_bin  (r_count),
    .o_busy (w_busy),
    .o_done (w_done),
    .o_bcd  (w_bcd)
  );

  // Latch encoded digits and pulse o_upd when the converter finishes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sseg <= {DIGITS{SEG_0}};
      r_upd  <= 1'b0;
    end else begin
      r_upd <= w_done;
      if (w_done) begin
        for (int d = 0; d < DIGITS; d++) begin
          r_sseg[7*d +: 7] <= seg7(w_bcd[4*d +: 4]);
        end
      end
    end
  end

  assign o_tick  = r_tick;
  assign o_count = r_count;
  assign o_busy  = w_busy;
  assign o_upd   = r_upd;
  assign o_sseg  = r_sseg;

endmodule
